// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA drawing datapath.
// Screen geometry, pixel bus widths, FSM state encoding and the on-screen test.
package vga_draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_BLUE  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // True when a (possibly wrapped) coordinate lies inside the visible screen.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_block_draw_arbiter_if.sv
// Client request / VGA pixel-port bundle for vga_block_draw_arbiter.
// master = clients + adapter side, slave = the arbiter.
interface vga_block_draw_arbiter_if
  import vga_draw_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]          req;
  logic [X_W*NUM_REQ-1:0]      req_x;
  logic [Y_W*NUM_REQ-1:0]      req_y;
  logic [COLOUR_W*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]          ack;
  logic                        busy;
  logic [X_W-1:0]              vga_x;
  logic [Y_W-1:0]              vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_plot;

  modport master (
    output req, req_x, req_y, req_colour,
    input  ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output ack, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_rr_ptr and wraps.
// Produces a one-hot grant and its encoded index (both zero when nothing requests).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_grant_idx_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_cand;
  logic             w_found;

  // First requester at or after the pointer, modulo NUM_REQ.
  always_comb begin
    o_grant_c     = '0;
    o_grant_idx_c = '0;
    w_found       = 1'b0;
    w_cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = SUM_W'(i_rr_ptr) + SUM_W'(k);
      if (w_cand >= SUM_W'(NUM_REQ)) begin
        w_cand = w_cand - SUM_W'(NUM_REQ);
      end
      if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
        w_found                        = 1'b1;
        o_grant_c[w_cand[IDX_W-1:0]]   = 1'b1;
        o_grant_idx_c                  = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vga_block_draw_arbiter.sv
// Shares the VGA pixel-write port between block-drawing clients (round-robin).
// Optional VGA_BLOCK_CLIP_EN suppresses plot for pixels outside the 160x120 screen.
module vga_block_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  vga_block_draw_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned L        = $clog2(BLOCK_SIZE);
  localparam int unsigned CNT_W    = (L == 0) ? 1 : 2 * L;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLOCK_SIZE * BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] X_MASK   = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t               r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_n;
  logic [IDX_W-1:0]     r_gidx, w_gidx_n;
  logic [NUM_REQ-1:0]   r_grant, w_grant_n;
  pixel_t               r_base, w_base_n;
  logic [NUM_REQ-1:0]   r_ack, w_ack_n;
  logic                 r_busy, w_busy_n;
  logic                 r_plot, w_plot_n;
  logic [X_W-1:0]       r_vga_x, w_vga_x_n;
  logic [Y_W-1:0]       r_vga_y, w_vga_y_n;
  logic [COLOUR_W-1:0]  r_vga_colour, w_vga_colour_n;
  logic                 w_draw;

  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [IDX_W-1:0]     w_arb_idx;
  pixel_t               w_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req         (bus.req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_c     (w_arb_grant),
    .o_grant_idx_c (w_arb_idx)
  );

  // Request payload of the client the arbiter currently picks.
  assign w_sel.x      = bus.req_x[w_arb_idx * X_W +: X_W];
  assign w_sel.y      = bus.req_y[w_arb_idx * Y_W +: Y_W];
  assign w_sel.colour = bus.req_colour[w_arb_idx * COLOUR_W +: COLOUR_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= '0;
      r_gidx       <= '0;
      r_grant      <= '0;
      r_base       <= '0;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= COL_BLACK;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_rr_ptr     <= w_rr_ptr_n;
      r_gidx       <= w_gidx_n;
      r_grant      <= w_grant_n;
      r_base       <= w_base_n;
      r_ack        <= w_ack_n;
      r_busy       <= w_busy_n;
      r_plot       <= w_plot_n;
      r_vga_x      <= w_vga_x_n;
      r_vga_y      <= w_vga_y_n;
      r_vga_colour <= w_vga_colour_n;
    end
  end

  // Next state plus the pixel that will be presented after the coming edge.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_rr_ptr_n     = r_rr_ptr;
    w_gidx_n       = r_gidx;
    w_grant_n      = r_grant;
    w_base_n       = r_base;
    w_ack_n        = '0;
    w_draw         = 1'b0;
    w_plot_n       = 1'b0;
    w_vga_x_n      = '0;
    w_vga_y_n      = '0;
    w_vga_colour_n = COL_BLACK;

    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_n = DRAW;
          w_gidx_n  = w_arb_idx;
          w_grant_n = w_arb_grant;
          w_base_n  = w_sel;
          w_cnt_n   = '0;
          w_draw    = 1'b1;
        end
      end
      DRAW: begin
        if (r_cnt == CNT_MAX) begin
          w_state_n = DONE;
          w_ack_n   = r_grant;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
          w_draw  = 1'b1;
        end
      end
      DONE: begin
        w_state_n  = IDLE;
        w_rr_ptr_n = (r_gidx == LAST_IDX) ? '0 : r_gidx + IDX_W'(1);
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    // Row-major walk: low counter bits step x, high bits step y; sums wrap.
    if (w_draw) begin
      w_vga_x_n      = w_base_n.x + X_W'(w_cnt_n & X_MASK);
      w_vga_y_n      = w_base_n.y + Y_W'(w_cnt_n >> L);
      w_vga_colour_n = w_base_n.colour;
`ifdef VGA_BLOCK_CLIP_EN
      w_plot_n       = on_screen(w_vga_x_n, w_vga_y_n);
`else
      w_plot_n       = 1'b1;
`endif
    end

    w_busy_n = (w_state_n != IDLE);
  end

  assign bus.ack        = r_ack;
  assign bus.busy       = r_busy;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_plot;

endmodule

// File: tb/tb_vga_block_draw_arbiter.sv
// Self-checking bench for vga_block_draw_arbiter against a transaction-level model
// (round-robin grant order + row-major block pixel lists). Honours VGA_BLOCK_CLIP_EN.
module tb_vga_block_draw_arbiter;
  import vga_draw_pkg::*;

  localparam int NR   = 3;
  localparam int BS   = 4;
  localparam int NPIX = BS * BS;
  localparam int PER  = NPIX + 2;

  logic clk;
  logic resetn;

  vga_block_draw_arbiter_if #(.NUM_REQ(NR)) bus ();

  vga_block_draw_arbiter #(
    .NUM_REQ    (NR),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int cx[NR], cy[NR], ccol[NR], want[NR], remaining[NR];
  int model_ptr;
  int chg_cyc;
  int chg_val;
  int end_cyc;
  bit timed_out;

  logic [18:0]   pix_q[$], exp_pix_q[$];
  logic [NR-1:0] ack_q[$], exp_ack_q[$];
  int            ack_cyc_q[$];

  function automatic logic [18:0] pix(input bit p, input int x, input int y, input int c);
    return {p, 8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic drive_data();
    for (int c = 0; c < NR; c++) begin
      bus.req_x[c*8 +: 8]      = 8'(cx[c]);
      bus.req_y[c*7 +: 7]      = 7'(cy[c]);
      bus.req_colour[c*3 +: 3] = 3'(ccol[c]);
    end
  endtask

  // Reference: serve pending clients round-robin, each a row-major BSxBS block.
  task automatic model_expect();
    int w[NR];
    int c, x, y;
    bit p;
    logic [NR-1:0] a;
    exp_pix_q.delete();
    exp_ack_q.delete();
    for (int i = 0; i < NR; i++) w[i] = want[i];
    forever begin
      c = -1;
      for (int k = 0; k < NR; k++)
        if (c < 0 && w[(model_ptr + k) % NR] > 0) c = (model_ptr + k) % NR;
      if (c < 0) break;
      w[c]--;
      for (int i = 0; i < NPIX; i++) begin
        x = (cx[c] + i % BS) % 256;
        y = (cy[c] + i / BS) % 128;
        p = 1'b1;
`ifdef VGA_BLOCK_CLIP_EN
        p = (x < 160) && (y < 120);
`endif
        exp_pix_q.push_back(pix(p, x, y, ccol[c]));
      end
      a = '0;
      a[c] = 1'b1;
      exp_ack_q.push_back(a);
      model_ptr = (c + 1) % NR;
    end
  endtask

  // Client behaviour: hold req while services remain, consume one per ack; record outputs.
  task automatic run_traffic(input int max_cyc);
    int cyc;
    pix_q.delete();
    ack_q.delete();
    ack_cyc_q.delete();
    timed_out = 1'b0;
    cyc = 0;
    for (int c = 0; c < NR; c++) remaining[c] = want[c];
    for (int c = 0; c < NR; c++) bus.req[c] = (remaining[c] > 0);
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.busy && bus.ack == '0)
        pix_q.push_back({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour});
      if (bus.ack != '0) begin
        ack_q.push_back(bus.ack);
        ack_cyc_q.push_back(cyc);
        for (int c = 0; c < NR; c++) if (bus.ack[c] && remaining[c] > 0) remaining[c]--;
      end
      if (cyc == chg_cyc) bus.req_x[15:8] = 8'(chg_val);
      for (int c = 0; c < NR; c++) bus.req[c] = (remaining[c] > 0);
      if (!bus.busy && bus.req == '0) break;
      if (cyc >= max_cyc) begin
        timed_out = 1'b1;
        break;
      end
    end
    end_cyc = cyc;
    bus.req = '0;
  endtask

  task automatic apply_reset();
    bus.req = '0;
    chg_cyc = -1;
    resetn  = 1'b0;
    repeat (2) @(negedge clk);
    resetn  = 1'b1;
    @(negedge clk);
    model_ptr = 0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    bus.req = 3'b111;
    @(negedge clk);
    n_cmp++;
    if ({bus.ack, bus.busy, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%h want 0", {bus.ack, bus.busy, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
    apply_reset();
    n_cmp++;
    if ({bus.ack, bus.busy, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%h want 0", {bus.ack, bus.busy, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot});
    end
  endtask

  task automatic test_single();
    want = '{1, 0, 0};
    cx[0] = 80; cy[0] = 60; ccol[0] = int'(COL_BLUE);
    drive_data();
    model_expect();
    run_traffic(100);
    n_cmp++;
    if (timed_out || pix_q.size() != NPIX || ack_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_len: pixels=%0d acks=%0d timeout=%0b want %0d/1/0", pix_q.size(), ack_q.size(), timed_out, NPIX);
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL single_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
    if (ack_q.size() > 0) begin
      n_cmp++;
      if (ack_q[0] !== 3'b001 || ack_cyc_q[0] != NPIX + 1) begin
        n_fail++;
        $display("FAIL single_ack: ack=%b at cycle %0d want 001 at %0d", ack_q[0], ack_cyc_q[0], NPIX + 1);
      end
    end
    n_cmp++;
    if (end_cyc != NPIX + 2) begin
      n_fail++;
      $display("FAIL single_busy_drop: busy low at cycle %0d want %0d", end_cyc, NPIX + 2);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    want = '{1, 1, 1};
    cx = '{10, 20, 30}; cy = '{5, 15, 25}; ccol = '{1, 2, 3};
    drive_data();
    model_expect();
    run_traffic(200);
    n_cmp++;
    if (timed_out || pix_q.size() != exp_pix_q.size() || ack_q.size() != 3) begin
      n_fail++;
      $display("FAIL simul_len: pixels=%0d acks=%0d timeout=%0b want %0d/3/0", pix_q.size(), ack_q.size(), timed_out, exp_pix_q.size());
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL simul_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
    for (int k = 0; k < ack_q.size() && k < 3; k++) begin
      n_cmp++;
      if (ack_q[k] !== 3'(1 << k) || ack_cyc_q[k] != NPIX + 1 + PER * k) begin
        n_fail++;
        $display("FAIL simul_ack[%0d]: ack=%b at %0d want %b at %0d", k, ack_q[k], ack_cyc_q[k], 3'(1 << k), NPIX + 1 + PER * k);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    want = '{2, 1, 0};
    cx = '{50, 60, 0}; cy = '{40, 45, 0}; ccol = '{4, 5, 0};
    drive_data();
    model_expect();
    run_traffic(200);
    n_cmp++;
    if (timed_out || ack_q.size() != 3) begin
      n_fail++;
      $display("FAIL fair_len: acks=%0d timeout=%0b want 3/0", ack_q.size(), timed_out);
    end else begin
      n_cmp++;
      if (ack_q[0] !== 3'b001 || ack_q[1] !== 3'b010 || ack_q[2] !== 3'b001) begin
        n_fail++;
        $display("FAIL fair_order: got %b,%b,%b want 001,010,001", ack_q[0], ack_q[1], ack_q[2]);
      end
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL fair_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
  endtask

  task automatic test_latch();
    want = '{0, 1, 0};
    cx[1] = 40; cy[1] = 30; ccol[1] = 6;
    drive_data();
    model_expect();
    chg_cyc = 6;
    chg_val = 100;
    run_traffic(100);
    chg_cyc = -1;
    n_cmp++;
    if (timed_out || pix_q.size() != NPIX || ack_q.size() != 1) begin
      n_fail++;
      $display("FAIL latch_len: pixels=%0d acks=%0d timeout=%0b want %0d/1/0", pix_q.size(), ack_q.size(), timed_out, NPIX);
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL latch_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
  endtask

  task automatic test_wrap_clip();
    int plots;
    int exp_plots;
    want = '{0, 0, 1};
    cx[2] = 158; cy[2] = 118; ccol[2] = 7;
    drive_data();
    model_expect();
    run_traffic(100);
`ifdef VGA_BLOCK_CLIP_EN
    exp_plots = 4;
`else
    exp_plots = NPIX;
`endif
    plots = 0;
    foreach (pix_q[i]) plots += int'(pix_q[i][18]);
    n_cmp++;
    if (timed_out || pix_q.size() != NPIX || plots != exp_plots) begin
      n_fail++;
      $display("FAIL wrap_plots: draw=%0d plots=%0d timeout=%0b want %0d/%0d/0", pix_q.size(), plots, timed_out, NPIX, exp_plots);
    end
    n_cmp++;
    if (ack_q.size() != 1 || ack_cyc_q[0] != NPIX + 1) begin
      n_fail++;
      $display("FAIL wrap_ack: acks=%0d cycle=%0d want 1 at %0d", ack_q.size(), (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, NPIX + 1);
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL wrap_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NR; c++) begin
        want[c] = $urandom_range(2, 0);
        cx[c]   = $urandom_range(1, 0) ? $urandom_range(255, 150) : $urandom_range(255, 0);
        cy[c]   = $urandom_range(1, 0) ? $urandom_range(127, 110) : $urandom_range(127, 0);
        ccol[c] = $urandom_range(7, 0);
      end
      if (want[0] + want[1] + want[2] == 0) want[$urandom_range(NR - 1, 0)] = 1;
      drive_data();
      model_expect();
      run_traffic(400);
      n_cmp++;
      if (timed_out || pix_q.size() != exp_pix_q.size() || ack_q.size() != exp_ack_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_len: pixels=%0d acks=%0d timeout=%0b want %0d/%0d/0", it, pix_q.size(), ack_q.size(), timed_out, exp_pix_q.size(), exp_ack_q.size());
      end
      for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
        n_cmp++;
        if (pix_q[i] !== exp_pix_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_pix[%0d]: got %h want %h", it, i, pix_q[i], exp_pix_q[i]);
        end
      end
      for (int k = 0; k < ack_q.size() && k < exp_ack_q.size(); k++) begin
        n_cmp++;
        if (ack_q[k] !== exp_ack_q[k] || ack_cyc_q[k] != NPIX + 1 + PER * k) begin
          n_fail++;
          $display("FAIL rand%0d_ack[%0d]: ack=%b at %0d want %b at %0d", it, k, ack_q[k], ack_cyc_q[k], exp_ack_q[k], NPIX + 1 + PER * k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cx = '{12, 70, 90}; cy = '{8, 33, 44}; ccol = '{2, 3, 4};
    drive_data();
    bus.req = 3'b001;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== pix(1'b1, 15, 9, 2)) begin
      n_fail++;
      $display("FAIL midrst_pix7: got %h want %h", {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}, pix(1'b1, 15, 9, 2));
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.vga_plot, bus.busy, bus.ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_async: plot=%b busy=%b ack=%b want 0/0/000", bus.vga_plot, bus.busy, bus.ack);
    end
    bus.req = 3'b110;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.vga_plot, bus.busy, bus.ack} !== 5'b0) begin
        n_fail++;
        $display("FAIL midrst_held: plot=%b busy=%b ack=%b want 0/0/000", bus.vga_plot, bus.busy, bus.ack);
      end
    end
    resetn = 1'b1;
    model_ptr = 0;
    want = '{0, 1, 1};
    model_expect();
    run_traffic(200);
    n_cmp++;
    if (timed_out || ack_q.size() != 2 || ack_q[0] !== 3'b010) begin
      n_fail++;
      $display("FAIL midrst_first_grant: acks=%0d first=%b timeout=%0b want 2/010/0", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 3'b000, timed_out);
    end
    for (int i = 0; i < pix_q.size() && i < exp_pix_q.size(); i++) begin
      n_cmp++;
      if (pix_q[i] !== exp_pix_q[i]) begin
        n_fail++;
        $display("FAIL midrst_pix[%0d]: got %h want %h", i, pix_q[i], exp_pix_q[i]);
      end
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    chg_cyc        = -1;
    chg_val        = 0;
    model_ptr      = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_latch();
    test_wrap_clip();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_block_draw_arbiter.md
Name: vga_block_draw_arbiter

Overview:
- Shares the VGA adapter's single pixel-write port (x, y, colour, plot) between several drawing clients: snake head draw, tail erase and food draw.
- Each client requests one square block at a base coordinate. The block grants one client round-robin and sequences the BLOCK_SIZE x BLOCK_SIZE pixel writes.
- When the block is fully drawn, it pulses an ack back to that client.
- Sits between the snake/food datapaths and vga_adapter. It replaces free-running pixel-offset counters and the hard-wired plot=1.

Parameters:
- NUM_REQ, 3, number of requesting clients (2..8).
- BLOCK_SIZE, 4, block edge length in pixels. Must be a power of 2 (1..8).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-client draw request, level; bit i = client i.
- req_x  in  8*NUM_REQ  per-client block base x; client i uses bits [8i+7:8i].
- req_y  in  7*NUM_REQ  per-client block base y; client i uses bits [7i+6:7i].
- req_colour  in  3*NUM_REQ  per-client colour; client i uses bits [3i+2:3i].
- ack  out  NUM_REQ  one-cycle pulse to the granted client on completion.
- busy  out  1  high whenever state != IDLE.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour to the adapter.
- vga_plot  out  1  pixel write enable to the adapter.

Behaviour:
- Reset (async) values:
  - state=IDLE; rr_ptr=0; pixel counter=0; latched base/colour=0.
  - All outputs 0: ack, busy, vga_x, vga_y, vga_colour, vga_plot.
- Outputs depend only on registered state (no combinational path from req to outputs).
- FSM states:
  - IDLE:
    - If req != 0, grant one client g (arbitration below). At that edge, latch req_x/req_y/req_colour of g, clear the counter and go to DRAW.
    - If req == 0, stay in IDLE.
  - DRAW:
    - vga_plot=1 every cycle.
    - vga_x = base_x + cnt[L-1:0] and vga_y = base_y + cnt[2L-1:L], where L = log2(BLOCK_SIZE). Pixel order is row-major: x fastest.
    - vga_colour = latched colour.
    - The counter increments each cycle. After BLOCK_SIZE^2 cycles (cnt at max), go to DONE.
  - DONE:
    - Exactly one cycle: ack[g]=1, vga_plot=0.
    - rr_ptr <= (g+1) mod NUM_REQ.
    - Next state is IDLE.
- Arbitration (round-robin):
  - Search starts at rr_ptr and wraps.
  - After reset, client 0 wins a simultaneous request.
- Timing:
  - req high in IDLE at edge E → first pixel on the outputs after E → 16 plot cycles (BLOCK_SIZE=4) → ack in the following cycle → IDLE.
  - Block period is BLOCK_SIZE^2 + 2 cycles, including the IDLE cycle.
- Handshake:
  - req_x/req_y/req_colour only need to be stable in the grant cycle, because they are latched.
  - The client must drop req in the cycle after ack. If req is still high, it is re-arbitrated as a new request; round-robin gives other pending clients priority first.
  - If req drops mid-DRAW, the block is still completed and ack still pulses (no abort).
- Width rules: coordinate sums are truncated, so x wraps mod 256 and y wraps mod 128 (no saturation).
- Reset asserted mid-DRAW:
  - vga_plot drops immediately (async) and no ack is issued.
  - The partial block stays on screen; redrawing it is the client's responsibility.

Optional Feature:
- Macro: VGA_BLOCK_CLIP_EN.
- Defined: vga_plot is forced to 0 for any DRAW pixel with computed x >= 160 or y >= 120. The truncated sum is used, so wrapped pixels are also tested. Cycle count and ack timing are unchanged.
- Undefined: no clipping; every DRAW cycle plots. Off-screen writes go to the adapter, which ignores or wraps them per its own rules.

Decomposition:
- Shared package vga_draw_pkg:
  - SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3.
  - Colour constants: COL_BLACK=3'b000, COL_BLUE=3'b001.
  - State typedef {IDLE, DRAW, DONE}.
- One sub-module: rr_arbiter.
  - Inputs: req and rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

Test Plan:
- Single request: reset, then req=3'b001, req_x[0]=80, req_y[0]=60, colour=001 → 16 plot cycles with (x,y) = (80,60),(81,60),(82,60),(83,60),(80,61)...(83,63), colour 001 → ack=3'b001 one cycle → busy low.
- Simultaneous requests: all three req high, held until each client's own ack → grant order 0,1,2. Acks are spaced 18 cycles apart, and each block uses its own latched coordinates/colour.
- Round-robin fairness: client 0 re-asserts req immediately after its ack while client 1 is pending → client 1 is served before client 0's second grant.
- Data latching: change req_x[1] from 40 to 100 during client 1's DRAW → all 16 pixels still use base x 40.
- Wrap/clip: req_x=158, req_y=118.
  - Without VGA_BLOCK_CLIP_EN: 16 plots, including x=160,161 and y=120,121.
  - With the macro defined: plot is asserted only for x ∈ {158,159}, y ∈ {118,119} (4 pixels). The ack is still at cycle 17.
- Reset mid-operation: assert resetn=0 at DRAW pixel 7 → vga_plot=0 and busy=0 asynchronously, no ack. After release with req=3'b110 → client 1 is granted first (rr_ptr=0 and client 0 is not requesting).
